rtc_bus_cycle: RTL and testbench

// - Bus-cycle engine directly below the RTC read/write sequencer FSMs: runs one full multiplexed address+data

---
 rtl/rtc_bus_pkg.sv | 36 +++
 rtl/rtc_phase_timer.sv | 24 ++
 rtl/rtc_bus_cycle.sv | 152 +++++++++++++++
 tb/tb_rtc_bus_cycle.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC parallel-bus cycle engine: phase encoding,
// RTC register map and the per-phase counter reload helper.
package rtc_bus_pkg;

    typedef logic [2:0] state_t;

    // Address and data phases share SETUP/ACT/HOLD; a separate flag selects which one is running.
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_ACT   = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam logic [7:0] SEG      = 8'h21;
    localparam logic [7:0] MIN      = 8'h22;
    localparam logic [7:0] HORA     = 8'h23;
    localparam logic [7:0] DIA      = 8'h24;
    localparam logic [7:0] MES      = 8'h25;
    localparam logic [7:0] ANIO     = 8'h26;
    localparam logic [7:0] SEG_TIM  = 8'h41;
    localparam logic [7:0] MIN_TIM  = 8'h42;
    localparam logic [7:0] HORA_TIM = 8'h43;
    localparam logic [7:0] COM_CYT  = 8'hF0;

    function automatic logic [7:0] phase_load(input state_t st, input logic [7:0] t_act,
                                              input logic [7:0] t_hold, input logic [7:0] t_gap);
        case (st)
            ST_ACT:  return t_act - 8'd1;
            ST_HOLD: return t_hold - 8'd1;
            ST_GAP:  return t_gap - 8'd1;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that parks at zero; the zero flag ends the current bus phase.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// One complete multiplexed address+data access on the RTC parallel bus per accepted start.
// Every bus output is registered from the next-state decode, so pins change cleanly on the clock.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_ACT  = 10,
    parameter int T_HOLD = 3,
    parameter int T_GAP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_read,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nxt;
    logic       data_phase, data_phase_nxt;
    logic       read_q;
    logic [7:0] addr_q, wdata_q;
    logic       phase_zero;
    logic       accept;
    logic       read_sel;
    logic [7:0] addr_sel, wdata_sel;

    logic [7:0] ad_out_nxt;
    logic       ad_oe_nxt, a_d_nxt, cs_nxt, rd_nxt, wr_nxt, busy_nxt, done_nxt;

    assign accept    = (state == ST_IDLE) && start;
    assign read_sel  = accept ? is_read : read_q;
    assign addr_sel  = accept ? addr    : addr_q;
    assign wdata_sel = accept ? wdata   : wdata_q;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state_nxt != state),
        .load_value (phase_load(state_nxt, 8'(T_ACT), 8'(T_HOLD), 8'(T_GAP))),
        .zero       (phase_zero)
    );

    always_comb begin
        state_nxt      = state;
        data_phase_nxt = data_phase;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt      = ST_SETUP;
                    data_phase_nxt = 1'b0;
                end
            end
            ST_SETUP: if (phase_zero) state_nxt = ST_ACT;
            ST_ACT:   if (phase_zero) state_nxt = ST_HOLD;
            ST_HOLD:  if (phase_zero) state_nxt = data_phase ? ST_DONE : ST_GAP;
            ST_GAP: begin
                if (phase_zero) begin
                    state_nxt      = ST_SETUP;
                    data_phase_nxt = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A read data phase never drives the pad, which keeps ad_oe low whenever rd is low.
    always_comb begin
        a_d_nxt    = 1'b1;
        cs_nxt     = 1'b1;
        rd_nxt     = 1'b1;
        wr_nxt     = 1'b1;
        ad_oe_nxt  = 1'b0;
        ad_out_nxt = 8'd0;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_SETUP, ST_ACT, ST_HOLD: begin
                a_d_nxt    = data_phase_nxt;
                ad_oe_nxt  = !data_phase_nxt || !read_sel;
                ad_out_nxt = data_phase_nxt ? wdata_sel : addr_sel;
                cs_nxt     = (state_nxt == ST_HOLD);
                if (state_nxt == ST_ACT) begin
                    if (data_phase_nxt && read_sel) rd_nxt = 1'b0;
                    else                            wr_nxt = 1'b0;
                end
            end
            ST_DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            data_phase <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
        end else begin
            state      <= state_nxt;
            data_phase <= data_phase_nxt;
            if (accept) begin
                read_q  <= is_read;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_d    <= 1'b1;
            cs     <= 1'b1;
            rd     <= 1'b1;
            wr     <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            a_d    <= a_d_nxt;
            cs     <= cs_nxt;
            rd     <= rd_nxt;
            wr     <= wr_nxt;
            ad_oe  <= ad_oe_nxt;
            ad_out <= ad_out_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Read data is taken on the last strobe-low cycle, while the RTC is still driving AD.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 8'd0;
        end else if ((state == ST_ACT) && data_phase && read_q && phase_zero) begin
            rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: directed scenarios plus randomized traffic, all checked every cycle
// against an offset-based model of one access (offset 1 = first address cycle, 33 = done).
module tb_rtc_bus_cycle;
    import rtc_bus_pkg::*;

    localparam int T_ACT  = 10;
    localparam int T_HOLD = 3;
    localparam int T_GAP  = 4;

    localparam int O_AA_END = 1 + T_ACT;
    localparam int O_AH_END = O_AA_END + T_HOLD;
    localparam int O_DS     = O_AH_END + T_GAP + 1;
    localparam int O_DA_END = O_DS + T_ACT;
    localparam int O_DH_END = O_DA_END + T_HOLD;
    localparam int O_DONE   = O_DH_END + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       is_read = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] ad_in = 8'd0;
    logic [7:0] ad_out, rdata;
    logic       ad_oe, a_d, cs, rd, wr, busy, done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   check_en = 1'b0;
    bit   rand_ad_in = 1'b0;

    bit         m_act = 1'b0;
    int         m_off = 0;
    bit         m_read = 1'b0;
    logic [7:0] m_addr = 8'd0;
    logic [7:0] m_wdata = 8'd0;
    logic [7:0] m_rdata = 8'd0;
    logic       prev_done = 1'b0;

    logic [7:0] addr_table [10] = '{SEG, MIN, HORA, DIA, MES, ANIO, SEG_TIM, MIN_TIM, HORA_TIM, COM_CYT};

    always #5 clk = ~clk;

    rtc_bus_cycle dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .is_read (is_read),
        .addr    (addr),
        .wdata   (wdata),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .a_d     (a_d),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [7:0] a, input logic [7:0] d);
        start   = s;
        is_read = r;
        addr    = a;
        wdata   = d;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ad_in) ad_in = 8'($urandom);
    endtask

    // Expected pins for a given offset into an access: {a_d, cs, rd, wr, ad_oe, busy, done}.
    function automatic void expected_bus(input bit act, input int off, input bit rdq,
                                         output logic [6:0] bits, output logic [7:0] drive);
        bit in_addr  = act && off >= 1 && off <= O_AH_END;
        bit addr_cs  = act && off >= 1 && off <= O_AA_END;
        bit addr_wr  = act && off >= 2 && off <= O_AA_END;
        bit data_cs  = act && off >= O_DS && off <= O_DA_END;
        bit data_str = act && off > O_DS && off <= O_DA_END;
        bit data_drv = act && off >= O_DS && off <= O_DH_END && !rdq;
        bits  = {!in_addr, !(addr_cs || data_cs), !(data_str && rdq),
                 !(addr_wr || (data_str && !rdq)), in_addr || data_drv,
                 act, act && off == O_DONE};
        drive = in_addr ? m_addr : m_wdata;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_act   = 1'b0;
            m_off   = 0;
            m_rdata = 8'd0;
        end else if (m_act) begin
            if (m_read && m_off == O_DA_END) m_rdata = ad_in;
            if (m_off == O_DONE) m_act = 1'b0;
            else                 m_off++;
        end else if (start) begin
            m_act   = 1'b1;
            m_off   = 1;
            m_read  = is_read;
            m_addr  = addr;
            m_wdata = wdata;
        end
    end

    always @(negedge clk) begin
        logic [6:0] e_bits;
        logic [7:0] e_drive;
        if (check_en) begin
            expected_bus(m_act, m_off, m_read, e_bits, e_drive);
            checkOutput("bus_pins", 32'({a_d, cs, rd, wr, ad_oe, busy, done}), 32'(e_bits));
            if (e_bits[2]) checkOutput("ad_out", 32'(ad_out), 32'(e_drive));
            checkOutput("rdata", 32'(rdata), 32'(m_rdata));
            checkOutput("rd_wr_both_low", 32'(!rd && !wr), 32'd0);
            checkOutput("oe_while_rd", 32'(ad_oe && !rd), 32'd0);
            checkOutput("done_width", 32'(done && prev_done), 32'd0);
            prev_done = done;
        end
    end

    // Runs one access from the current negedge and measures its strobes and latency.
    task automatic runAccess(input logic r, input logic [7:0] a, input logic [7:0] d,
                             output int lat, output int wr_addr, output int wr_data,
                             output int rd_low, output int oe_rd_low, output logic [7:0] rd_done);
        int k0;
        lat = -1; wr_addr = 0; wr_data = 0; rd_low = 0; oe_rd_low = 0; rd_done = 8'd0;
        applyStimulus(1'b1, r, a, d);
        k0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            if (!wr && !a_d) wr_addr++;
            if (!wr && a_d)  wr_data++;
            if (!rd)         rd_low++;
            if (!rd && ad_oe) oe_rd_low++;
            if (done) begin
                lat = cyc - k0;
                rd_done = rdata;
            end
            if (lat < 0) tick();
        end
        if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, wa, wd, rl, oer, k0, ndone, hold;
        int dcyc [3];
        logic [7:0] rdd;

        repeat (2) tick();
        check_en = 1'b1;
        repeat (8) tick();
        checkOutput("reset_pins", 32'({a_d, cs, rd, wr, ad_oe, busy, done}), 32'b1111000);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] write access");
        runAccess(1'b0, SEG, 8'h45, lat, wa, wd, rl, oer, rdd);
        checkOutput("wr_latency", 32'(lat), 32'd33);
        checkOutput("wr_addr_strobe", 32'(wa), 32'd10);
        checkOutput("wr_data_strobe", 32'(wd), 32'd10);
        checkOutput("wr_rd_low", 32'(rl), 32'd0);

        $display("[TB] reset inside address strobe");
        applyStimulus(1'b1, 1'b0, MIN, 8'h5A);
        k0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < k0 + 11) tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_pins", 32'({a_d, cs, rd, wr, ad_oe, busy}), 32'b111100);
        checkOutput("rst_mid_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        checkOutput("rst_mid_no_done", 32'(ndone), 32'd0);

        $display("[TB] read access");
        ad_in = 8'h17;
        runAccess(1'b1, HORA_TIM, 8'hC3, lat, wa, wd, rl, oer, rdd);
        checkOutput("rd_latency", 32'(lat), 32'd33);
        checkOutput("rd_strobe", 32'(rl), 32'd10);
        checkOutput("rd_oe_low", 32'(oer), 32'd0);
        checkOutput("rd_data_wr", 32'(wd), 32'd0);
        checkOutput("rd_rdata", 32'(rdd), 32'h17);

        $display("[TB] request removed, extra starts ignored");
        applyStimulus(1'b1, 1'b0, DIA, 8'h09);
        k0 = cyc;
        tick();
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            start = (cyc == k0 + 4) || (cyc == k0 + 19);
            if (done) ndone++;
            tick();
        end
        start = 1'b0;
        checkOutput("removed_done_count", 32'(ndone), 32'd1);

        $display("[TB] back-to-back accesses");
        applyStimulus(1'b1, 1'b0, COM_CYT, 8'h80);
        ndone = 0;
        for (int i = 0; i < 150 && ndone < 3; i++) begin
            tick();
            if (done) begin
                dcyc[ndone] = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            checkOutput("b2b_spacing_1", 32'(dcyc[1] - dcyc[0]), 32'd34);
            checkOutput("b2b_spacing_2", 32'(dcyc[2] - dcyc[1]), 32'd34);
        end
        repeat (3) tick();

        $display("[TB] randomized traffic");
        rand_ad_in = 1'b1;
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), addr_table[$urandom_range(0, 9)], 8'($urandom));
            hold = $urandom_range(1, 40);
            repeat (hold) begin
                tick();
                is_read = 1'($urandom_range(0, 1));
                addr    = 8'($urandom);
                wdata   = 8'($urandom);
            end
            start = 1'b0;
            repeat ($urandom_range(0, 6)) tick();
        end
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
